// File: rtl/process_scheduler_if.sv
// Bus bundle between the ready-queue scheduler and its environment
// (channel/IO controller on the enqueue/requeue side, Core array on the
// per-core side).
//   master : drives enqueue/requeue requests and per-core status flags
//   slave  : the scheduler; drives enqueueReady, per-core messages/PIDs,
//            queueCount and the sticky overflow flag
// Per-core vectors are packed with core c at [3c+2:3c] for processorMessage
// and [pidBits*c +: pidBits] for resumeAddress.

`ifndef ADDRESS_BITS
`define ADDRESS_BITS 16
`endif
`ifndef PROCESSOR_MESSAGE_NONE
`define PROCESSOR_MESSAGE_NONE 3'd0
`endif
`ifndef PROCESSOR_MESSAGE_RESUME
`define PROCESSOR_MESSAGE_RESUME 3'd1
`endif

interface process_scheduler_if #(
  parameter int numCores  = 4,
  parameter int pidBits   = `ADDRESS_BITS,
  parameter int depthLog2 = 4
);
  logic                        enqueueValid;
  logic [pidBits-1:0]          enqueuePid;
  logic                        enqueueReady;
  logic                        requeueValid;
  logic [pidBits-1:0]          requeuePid;
  logic [numCores-1:0]         coreExecuting;
  logic [numCores-1:0]         coreReadyToReceive;
  logic [3*numCores-1:0]       processorMessage;
  logic [pidBits*numCores-1:0] resumeAddress;
  logic [depthLog2:0]          queueCount;
  logic                        overflow;

  modport master (
    output enqueueValid, enqueuePid, requeueValid, requeuePid,
           coreExecuting, coreReadyToReceive,
    input  enqueueReady, processorMessage, resumeAddress, queueCount, overflow
  );

  modport slave (
    input  enqueueValid, enqueuePid, requeueValid, requeuePid,
           coreExecuting, coreReadyToReceive,
    output enqueueReady, processorMessage, resumeAddress, queueCount, overflow
  );
endinterface

// File: rtl/process_scheduler.sv
// Ready-queue scheduler for the multicore stack machine.
// Holds PIDs of runnable processes in a circular FIFO and dispatches the head
// PID to an idle, ready core (round-robin starting at rr pointer) by holding
// RESUME + PID on that core's message lines until the core reports executing.
// Yielding processes come back through the requeue path, which has priority
// over new enqueues.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : process_scheduler_if.slave (enqueue/requeue inputs, per-core
//            executing/ready flags, per-core message/PID outputs, queueCount,
//            sticky overflow)

`ifndef ADDRESS_BITS
`define ADDRESS_BITS 16
`endif
`ifndef PROCESSOR_MESSAGE_NONE
`define PROCESSOR_MESSAGE_NONE 3'd0
`endif
`ifndef PROCESSOR_MESSAGE_RESUME
`define PROCESSOR_MESSAGE_RESUME 3'd1
`endif

module process_scheduler #(
  parameter int numCores  = 4,
  parameter int pidBits   = `ADDRESS_BITS,
  parameter int depthLog2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  process_scheduler_if.slave    bus
);
  localparam int DEPTH     = 1 << depthLog2;
  localparam int CORE_BITS = (numCores > 1) ? $clog2(numCores) : 1;
  localparam logic [depthLog2:0]   DEPTH_COUNT = (depthLog2 + 1)'(DEPTH);
  localparam logic [CORE_BITS-1:0] LAST_CORE   = CORE_BITS'(numCores - 1);

  typedef enum logic [1:0] {
    CORE_IDLE,
    CORE_RESUMING,
    CORE_RUNNING
  } core_state_t;

  // Queue storage and bookkeeping
  logic [pidBits-1:0]   queue_mem [DEPTH];
  logic [depthLog2-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [depthLog2:0]   count_reg, count_next;
  logic                 overflow_reg;
  logic [CORE_BITS-1:0] rr_reg;

  logic                 queue_full, queue_empty;
  logic                 enqueue_ready;
  logic                 push, pop, drop;
  logic [pidBits-1:0]   push_pid;
  logic [pidBits-1:0]   head_pid;

  // Grant selection
  logic [numCores-1:0]  eligible;
  logic                 grant_valid;
  logic [CORE_BITS-1:0] grant_core;

  assign queue_full    = (count_reg == DEPTH_COUNT);
  assign queue_empty   = (count_reg == '0);
  assign enqueue_ready = !queue_full && !bus.requeueValid;
  assign head_pid      = queue_mem[rd_ptr_reg];

  assign bus.enqueueReady = enqueue_ready;
  assign bus.queueCount   = count_reg;
  assign bus.overflow     = overflow_reg;

  // First eligible core at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_core  = '0;
    if (!queue_empty) begin
      for (int i = 0; i < numCores; i++) begin
        idx = (int'(rr_reg) + i) % numCores;
        if (!grant_valid && eligible[idx]) begin
          grant_valid = 1'b1;
          grant_core  = CORE_BITS'(idx);
        end
      end
    end
  end

  assign pop = grant_valid;

  // Requeue wins the single push slot. A requeue into a full queue is only
  // accepted when the head is popped the same cycle (the freed slot is the
  // one being written).
  always_comb begin
    push     = 1'b0;
    drop     = 1'b0;
    push_pid = bus.enqueuePid;
    if (bus.requeueValid) begin
      push_pid = bus.requeuePid;
      if (!queue_full || pop) begin
        push = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (bus.enqueueValid && enqueue_ready) begin
      push = 1'b1;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      rr_reg       <= '0;
    end else begin
      count_reg <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (drop) overflow_reg <= 1'b1;
      if (grant_valid) begin
        rr_reg <= (grant_core == LAST_CORE) ? '0 : grant_core + 1'b1;
      end
    end
  end

  // Storage carries no reset; contents are only meaningful below count_reg.
  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr_reg] <= push_pid;
  end

  // Per-core dispatch FSM: IDLE -> RESUMING (granted) -> RUNNING (core
  // reports executing) -> IDLE (core stops executing).
  for (genvar gi = 0; gi < numCores; gi++) begin : g_core
    core_state_t        state_reg, state_next;
    logic [pidBits-1:0] addr_reg;
    logic [2:0]         message;
    logic               granted;

    assign granted = grant_valid && (grant_core == CORE_BITS'(gi));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_reg <= CORE_IDLE;
        addr_reg  <= '0;
      end else begin
        state_reg <= state_next;
        if (granted) addr_reg <= head_pid;
      end
    end

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        CORE_IDLE:     if (granted) state_next = CORE_RESUMING;
        CORE_RESUMING: if (bus.coreExecuting[gi]) state_next = CORE_RUNNING;
        CORE_RUNNING:  if (!bus.coreExecuting[gi]) state_next = CORE_IDLE;
        default:       state_next = CORE_IDLE;
      endcase
    end

    always_comb begin
      message = `PROCESSOR_MESSAGE_NONE;
      if (state_reg == CORE_RESUMING) message = `PROCESSOR_MESSAGE_RESUME;
    end

    assign eligible[gi] = (state_reg == CORE_IDLE) && bus.coreReadyToReceive[gi];
    assign bus.processorMessage[3*gi +: 3]            = message;
    assign bus.resumeAddress[pidBits*gi +: pidBits]   = addr_reg;
  end

endmodule

// File: tb/tb_process_scheduler.sv
`ifndef PROCESSOR_MESSAGE_NONE
`define PROCESSOR_MESSAGE_NONE 3'd0
`endif
`ifndef PROCESSOR_MESSAGE_RESUME
`define PROCESSOR_MESSAGE_RESUME 3'd1
`endif

module tb_process_scheduler;
  localparam int NC = 4;
  localparam int PB = 16;
  localparam int DL = 4;
  localparam logic [2:0] NONE   = `PROCESSOR_MESSAGE_NONE;
  localparam logic [2:0] RESUME = `PROCESSOR_MESSAGE_RESUME;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  process_scheduler_if #(.numCores(NC), .pidBits(PB), .depthLog2(DL)) bus ();

  process_scheduler #(.numCores(NC), .pidBits(PB), .depthLog2(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [2:0] msg(input int c);
    return bus.processorMessage[3*c +: 3];
  endfunction

  function automatic logic [PB-1:0] addr(input int c);
    return bus.resumeAddress[PB*c +: PB];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.enqueueValid       = 1'b0;
    bus.enqueuePid         = '0;
    bus.requeueValid       = 1'b0;
    bus.requeuePid         = '0;
    bus.coreExecuting      = '0;
    bus.coreReadyToReceive = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Reset values straight out of power-up reset.
  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    for (int c = 0; c < NC; c++) begin
      checks++; if (msg(c) !== NONE) begin errors++; $display("FAIL reset_msg%0d: got %0h expected %0h", c, msg(c), NONE); end
      checks++; if (addr(c) !== '0) begin errors++; $display("FAIL reset_addr%0d: got %0h expected 0", c, addr(c)); end
    end
    checks++; if (bus.queueCount !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.queueCount); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    checks++; if (bus.enqueueReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.enqueueReady); end
    reset = 1'b0;
    tick();
    $display("test_reset: reset released, queue empty");
  endtask

  // One PID to one core: RESUME held until executing is seen, then NONE.
  task automatic test_single_dispatch();
    apply_reset();
    bus.coreReadyToReceive = 4'b0001;
    bus.enqueueValid = 1'b1;
    bus.enqueuePid   = 16'h0040;
    tick();
    bus.enqueueValid = 1'b0;
    checks++; if (bus.queueCount !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d expected 1", bus.queueCount); end
    checks++; if (msg(0) !== NONE) begin errors++; $display("FAIL single_not_same_cycle: got %0h expected %0h", msg(0), NONE); end
    tick();
    $display("test_single_dispatch: core0 msg %0h pid %h", msg(0), addr(0));
    checks++; if (msg(0) !== RESUME) begin errors++; $display("FAIL single_resume: got %0h expected %0h", msg(0), RESUME); end
    checks++; if (addr(0) !== 16'h0040) begin errors++; $display("FAIL single_addr: got %h expected 0040", addr(0)); end
    checks++; if (bus.queueCount !== 5'd0) begin errors++; $display("FAIL single_count0: got %0d expected 0", bus.queueCount); end
    checks++; if (msg(1) !== NONE) begin errors++; $display("FAIL single_other_core: got %0h expected %0h", msg(1), NONE); end
    tick();
    checks++; if (msg(0) !== RESUME) begin errors++; $display("FAIL single_hold: got %0h expected %0h", msg(0), RESUME); end
    checks++; if (addr(0) !== 16'h0040) begin errors++; $display("FAIL single_hold_addr: got %h expected 0040", addr(0)); end
    bus.coreExecuting = 4'b0001;
    tick();
    checks++; if (msg(0) !== NONE) begin errors++; $display("FAIL single_none_after_exec: got %0h expected %0h", msg(0), NONE); end
    bus.coreExecuting = 4'b0000;
    tick();
    tick();
    checks++; if (msg(0) !== NONE) begin errors++; $display("FAIL single_empty_idle: got %0h expected %0h", msg(0), NONE); end
  endtask

  // Four PIDs, four ready cores: one grant per cycle, cores 0..3, FIFO order.
  task automatic test_fanout();
    logic [PB-1:0] pids [4];
    pids[0] = 16'h0010; pids[1] = 16'h0020; pids[2] = 16'h0030; pids[3] = 16'h0040;
    apply_reset();
    bus.coreReadyToReceive = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        bus.enqueueValid = 1'b1;
        bus.enqueuePid   = pids[k];
      end else begin
        bus.enqueueValid = 1'b0;
      end
      tick();
      if (k >= 1) begin
        $display("test_fanout: core%0d msg %0h pid %h", k-1, msg(k-1), addr(k-1));
        checks++; if (msg(k-1) !== RESUME) begin errors++; $display("FAIL fanout_msg%0d: got %0h expected %0h", k-1, msg(k-1), RESUME); end
        checks++; if (addr(k-1) !== pids[k-1]) begin errors++; $display("FAIL fanout_addr%0d: got %h expected %h", k-1, addr(k-1), pids[k-1]); end
        if (k < 4) begin
          checks++; if (msg(k) !== NONE) begin errors++; $display("FAIL fanout_early%0d: got %0h expected %0h", k, msg(k), NONE); end
        end
      end
    end
    checks++; if (bus.queueCount !== 5'd0) begin errors++; $display("FAIL fanout_count: got %0d expected 0", bus.queueCount); end
  endtask

  // Fill to depth with no idle core, then requeue into the full queue.
  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.enqueueReady !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b expected 1", i, bus.enqueueReady); end
      bus.enqueueValid = 1'b1;
      bus.enqueuePid   = 16'h0100 + 16'(i);
      tick();
    end
    bus.enqueueValid = 1'b0;
    $display("test_overflow: queue filled, count %0d", bus.queueCount);
    checks++; if (bus.queueCount !== 5'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", bus.queueCount); end
    checks++; if (bus.enqueueReady !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", bus.enqueueReady); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow_yet: got %b expected 0", bus.overflow); end
    bus.requeueValid = 1'b1;
    bus.requeuePid   = 16'h0099;
    tick();
    bus.requeueValid = 1'b0;
    $display("test_overflow: requeue 0099 into full queue, overflow %b", bus.overflow);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", bus.overflow); end
    checks++; if (bus.queueCount !== 5'd16) begin errors++; $display("FAIL overflow_count: got %0d expected 16", bus.queueCount); end
    // Full queue, but a pop happens the same cycle: requeue is accepted.
    bus.coreReadyToReceive = 4'b0001;
    bus.requeueValid = 1'b1;
    bus.requeuePid   = 16'h0077;
    tick();
    bus.requeueValid = 1'b0;
    bus.coreReadyToReceive = 4'b0000;
    $display("test_overflow: pop+requeue, core0 pid %h count %0d", addr(0), bus.queueCount);
    checks++; if (msg(0) !== RESUME) begin errors++; $display("FAIL popreq_msg: got %0h expected %0h", msg(0), RESUME); end
    checks++; if (addr(0) !== 16'h0100) begin errors++; $display("FAIL popreq_addr: got %h expected 0100", addr(0)); end
    checks++; if (bus.queueCount !== 5'd16) begin errors++; $display("FAIL popreq_count: got %0d expected 16", bus.queueCount); end
  endtask

  // Reset while core0 is mid-RESUME with a full queue and overflow set.
  task automatic test_reset_mid_run();
    tick();
    reset = 1'b1;
    tick();
    $display("test_reset_mid_run: reset asserted during RESUME");
    checks++; if (msg(0) !== NONE) begin errors++; $display("FAIL midreset_msg: got %0h expected %0h", msg(0), NONE); end
    checks++; if (addr(0) !== '0) begin errors++; $display("FAIL midreset_addr: got %h expected 0", addr(0)); end
    checks++; if (bus.queueCount !== 5'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", bus.queueCount); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow: got %b expected 0", bus.overflow); end
    checks++; if (bus.enqueueReady !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", bus.enqueueReady); end
    reset = 1'b0;
    bus.coreReadyToReceive = 4'b0001;
    tick();
    tick();
    checks++; if (msg(0) !== NONE) begin errors++; $display("FAIL midreset_lost_pid: got %0h expected %0h", msg(0), NONE); end
    bus.coreReadyToReceive = 4'b0000;
  endtask

  // Requeue and enqueue together: requeue wins, enqueue lands next cycle.
  task automatic test_requeue_priority();
    apply_reset();
    bus.enqueueValid = 1'b1;
    bus.enqueuePid   = 16'h00A1;
    bus.requeueValid = 1'b1;
    bus.requeuePid   = 16'h00B2;
    #1;
    checks++; if (bus.enqueueReady !== 1'b0) begin errors++; $display("FAIL prio_ready: got %b expected 0", bus.enqueueReady); end
    tick();
    bus.requeueValid = 1'b0;
    checks++; if (bus.queueCount !== 5'd1) begin errors++; $display("FAIL prio_count1: got %0d expected 1", bus.queueCount); end
    tick();
    bus.enqueueValid = 1'b0;
    checks++; if (bus.queueCount !== 5'd2) begin errors++; $display("FAIL prio_count2: got %0d expected 2", bus.queueCount); end
    bus.coreReadyToReceive = 4'b0011;
    tick();
    $display("test_requeue_priority: core0 pid %h", addr(0));
    checks++; if (msg(0) !== RESUME || addr(0) !== 16'h00B2) begin errors++; $display("FAIL prio_first: got %0h/%h expected %0h/00B2", msg(0), addr(0), RESUME); end
    checks++; if (msg(1) !== NONE) begin errors++; $display("FAIL prio_one_grant: got %0h expected %0h", msg(1), NONE); end
    tick();
    $display("test_requeue_priority: core1 pid %h", addr(1));
    checks++; if (msg(1) !== RESUME || addr(1) !== 16'h00A1) begin errors++; $display("FAIL prio_second: got %0h/%h expected %0h/00A1", msg(1), addr(1), RESUME); end
    checks++; if (bus.queueCount !== 5'd0) begin errors++; $display("FAIL prio_count0: got %0d expected 0", bus.queueCount); end
  endtask

  // Core1 returns to IDLE and picks up a queued PID; then with rr=2 and
  // cores 2,3 busy, the grant wraps to core0 ahead of core1.
  task automatic test_rr_wrap();
    apply_reset();
    bus.coreReadyToReceive = 4'b1100;
    bus.enqueueValid = 1'b1; bus.enqueuePid = 16'h0022; tick();
    bus.enqueuePid = 16'h0033; tick();
    bus.enqueueValid = 1'b0; tick();
    checks++; if (addr(2) !== 16'h0022 || addr(3) !== 16'h0033) begin errors++; $display("FAIL wrap_setup: got %h/%h expected 0022/0033", addr(2), addr(3)); end
    bus.coreExecuting = 4'b1100; tick();
    bus.coreReadyToReceive = 4'b0010;
    bus.enqueueValid = 1'b1; bus.enqueuePid = 16'h0011; tick();
    bus.enqueueValid = 1'b0; tick();
    checks++; if (msg(1) !== RESUME || addr(1) !== 16'h0011) begin errors++; $display("FAIL wrap_core1_first: got %0h/%h expected %0h/0011", msg(1), addr(1), RESUME); end
    bus.coreExecuting = 4'b1110; tick();
    // 0x55 queued while core1 still running and core0 not ready
    bus.coreReadyToReceive = 4'b1110;
    bus.enqueueValid = 1'b1; bus.enqueuePid = 16'h0055; tick();
    bus.enqueueValid = 1'b0; tick();
    checks++; if (bus.queueCount !== 5'd1) begin errors++; $display("FAIL wrap_held: got %0d expected 1", bus.queueCount); end
    bus.coreExecuting = 4'b1100; tick();
    checks++; if (msg(1) !== NONE || bus.queueCount !== 5'd1) begin errors++; $display("FAIL wrap_idle_first: got %0h/%0d expected %0h/1", msg(1), bus.queueCount, NONE); end
    tick();
    $display("test_rr_wrap: core1 pid %h", addr(1));
    checks++; if (msg(1) !== RESUME || addr(1) !== 16'h0055) begin errors++; $display("FAIL wrap_core1_55: got %0h/%h expected %0h/0055", msg(1), addr(1), RESUME); end
    checks++; if (msg(0) !== NONE) begin errors++; $display("FAIL wrap_core0_unready: got %0h expected %0h", msg(0), NONE); end
    bus.coreExecuting = 4'b1110; tick();
    bus.coreExecuting = 4'b1100; tick();
    bus.coreReadyToReceive = 4'b1111;
    bus.enqueueValid = 1'b1; bus.enqueuePid = 16'h0066; tick();
    bus.enqueuePid = 16'h0077; tick();
    bus.enqueueValid = 1'b0;
    $display("test_rr_wrap: core0 pid %h", addr(0));
    checks++; if (msg(0) !== RESUME || addr(0) !== 16'h0066) begin errors++; $display("FAIL wrap_core0: got %0h/%h expected %0h/0066", msg(0), addr(0), RESUME); end
    checks++; if (msg(1) !== NONE) begin errors++; $display("FAIL wrap_core1_waits: got %0h expected %0h", msg(1), NONE); end
    tick();
    $display("test_rr_wrap: core1 pid %h", addr(1));
    checks++; if (msg(1) !== RESUME || addr(1) !== 16'h0077) begin errors++; $display("FAIL wrap_core1_next: got %0h/%h expected %0h/0077", msg(1), addr(1), RESUME); end
    checks++; if (msg(2) !== NONE || msg(3) !== NONE) begin errors++; $display("FAIL wrap_busy_cores: got %0h/%0h expected %0h", msg(2), msg(3), NONE); end
  endtask

  initial begin
    test_reset();
    test_single_dispatch();
    test_fanout();
    test_overflow();
    test_reset_mid_run();
    test_requeue_priority();
    test_rr_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
